// File: rtl/k16_front_panel.sv
// K16 front panel: synchronized, debounced switches and buttons, command
// code encoder and LED registers behind an 8-word bus window.
module k16_debounce #(
    parameter int W   = 1,
    parameter int DEB = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] deb
);
    localparam int CW = (DEB > 2) ? $clog2(DEB) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEB - 1);

    logic [W-1:0]  s1;
    logic [W-1:0]  s2;
    logic [W-1:0]  last;
    logic [CW-1:0] cnt;

    // cnt counts cycles s2 has matched its previous value; saturates at CMAX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            last <= '0;
            cnt  <= '0;
            deb  <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            last <= s2;
            if (s2 != last)
                cnt <= '0;
            else if (cnt != CMAX)
                cnt <= cnt + CW'(1);
            if (s2 == last && cnt == CMAX)
                deb <= s2;
        end
    end
endmodule

module k16_front_panel #(
    parameter logic [15:0] BASE_ADDR       = 16'hFFF0,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          NUM_BUTTONS     = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            address,
    input  logic [15:0]            wr_data,
    input  logic                   write,
    output logic [15:0]            rd_data,
    output logic                   hit,
    input  logic [15:0]            sw_addr,
    input  logic [3:0]             sw_reg,
    input  logic [NUM_BUTTONS-1:0] btn,
    input  logic                   btn_stop,
    output logic                   stop,
    output logic [15:0]            led_addr,
    output logic [15:0]            led_data
);
    typedef enum logic [1:0] {
        IDLE,
        HELD,
        RELEASE
    } state_t;

    state_t state;
    state_t state_n;

    logic [19:0]            sw_db;
    logic [NUM_BUTTONS-1:0] btn_db;
    logic                   stop_db;
    logic [15:0]            code;
    logic [15:0]            code_n;
    logic [15:0]            low_code;
    logic                   dec;
    logic [2:0]             off;
    logic [15:0]            rd_n;

    k16_debounce #(.W(20), .DEB(DEBOUNCE_CYCLES)) u_sw (
        .clk   (clk),
        .reset (reset),
        .raw   ({sw_addr, sw_reg}),
        .deb   (sw_db)
    );

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        k16_debounce #(.W(1), .DEB(DEBOUNCE_CYCLES)) u_btn (
            .clk   (clk),
            .reset (reset),
            .raw   (btn[g]),
            .deb   (btn_db[g])
        );
    end

    k16_debounce #(.W(1), .DEB(DEBOUNCE_CYCLES)) u_stop (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_stop),
        .deb   (stop_db)
    );

    assign stop = stop_db;

    // scanning downward leaves the lowest pressed index in low_code
    always_comb begin
        low_code = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (btn_db[i])
                low_code = 16'(i + 1);
        end
    end

    always_comb begin
        state_n = state;
        code_n  = code;
        unique case (state)
            IDLE: begin
                code_n = '0;
                if (|btn_db) begin
                    code_n  = low_code;
                    state_n = HELD;
                end
            end
            HELD: begin
                if (!(|btn_db)) begin
                    code_n  = '0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                code_n  = '0;
                state_n = IDLE;
            end
            default: begin
                code_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            code  <= '0;
        end else begin
            state <= state_n;
            code  <= code_n;
        end
    end

    assign dec = (address[15:3] == BASE_ADDR[15:3]);
    assign off = address[2:0];

    always_comb begin
        rd_n = '0;
        unique case (off)
            3'd0: rd_n = sw_db[19:4];
            3'd1: rd_n = code;
            3'd2: rd_n = {12'b0, sw_db[3:0]};
            3'd3: rd_n = led_addr;
            3'd4: rd_n = led_data;
            3'd5: rd_n = {14'b0, stop_db, state != IDLE};
            default: rd_n = '0;
        endcase
    end

    // read mux sees pre-write LED values, so same-cycle reads return old data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            hit      <= 1'b0;
            led_addr <= '0;
            led_data <= '0;
        end else begin
            hit     <= dec;
            rd_data <= dec ? rd_n : 16'h0000;
            if (write && dec && off == 3'd3)
                led_addr <= wr_data;
            if (write && dec && off == 3'd4)
                led_data <= wr_data;
        end
    end
endmodule

// File: doc/k16_front_panel.md
Name: k16_front_panel

Overview:
- Memory-mapped front-panel peripheral on the K16Cpu bus.
- Synchronizes and debounces the physical address/register switches and the control push-buttons, and encodes the buttons into the CTRL_SWITCHES code the CPU polls.
- Latches CPU writes to ADDR_LEDS/DATA_LEDS and drives the LED pins.
- Sits directly beside RAM on the CPU bus; the top-level read mux selects rd_data when hit=1.

Parameters:
- BASE_ADDR, 16'hFFF0: base of the 8-word register window (offsets 0..7).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a synchronized input is accepted (≥2).
- NUM_BUTTONS, 9: control buttons; button i encodes to code i+1; code 0 = NONE.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- address  input  16  CPU bus address
- wr_data  input  16  CPU data_out
- write  input  1  CPU write strobe, sampled on posedge clk
- rd_data  output  16  registered read data, valid the cycle after address is presented
- hit  output  1  registered; 1 when rd_data belongs to this block
- sw_addr  input  16  raw address/data toggle switches (asynchronous)
- sw_reg  input  4  raw register-select switches (asynchronous)
- btn  input  NUM_BUTTONS  raw control buttons, active-high (asynchronous)
- btn_stop  input  1  raw STOP button (asynchronous)
- stop  output  1  debounced STOP level to the CPU stop input
- led_addr  output  16  ADDR_LEDS register
- led_data  output  16  DATA_LEDS register

Behaviour:
- Reset (async, active-high):
  - All outputs are 0.
  - Synchronizers, debounced values and counters are 0.
  - The encoder is in IDLE.
- Synchronization: every raw input passes through a 2-FF synchronizer before any other logic.
- Switch debounce: sw_addr and sw_reg are debounced as one 20-bit group.
  - Any change of the synchronized group restarts the counter.
  - The accepted value updates when the group has been unchanged for DEBOUNCE_CYCLES cycles.
  - Counter saturates; it never wraps.
- Button debounce: each btn bit and btn_stop has its own counter with the same rule.
  - stop = debounced btn_stop.
- Code encoder FSM, states IDLE, HELD, RELEASE:
  - IDLE: code=0. If any debounced button=1, code := lowest-index pressed bit + 1, go HELD.
  - HELD: code frozen. Additional presses are ignored. When all debounced buttons=0, go RELEASE.
  - RELEASE: code=0 for exactly one cycle, then IDLE. This guarantees the CPU sees NONE between two commands.
  - Simultaneous presses in IDLE: the lowest index wins.
- Register map, word offset from BASE_ADDR:
  - 0 ADDR_SWITCHES (ro): {debounced sw_addr}
  - 1 CTRL_SWITCHES (ro): {zero-extended code}
  - 2 REG_SWITCHES (ro): {12'b0, debounced sw_reg}
  - 3 ADDR_LEDS (rw)
  - 4 DATA_LEDS (rw)
  - 5 STATUS (ro): {14'b0, stop, fsm!=IDLE}
  - 6, 7: read 0, writes ignored.
- Decode: address[15:3]==BASE_ADDR[15:3]; offset = address[2:0].
- Read timing:
  - Read latency is exactly 1 cycle, matching RAM: rd_data and hit register on posedge clk from the current address.
  - When not decoded, rd_data=0 and hit=0.
- Write timing:
  - On posedge clk with write=1 and decode hit, offset 3/4 load wr_data into led_addr/led_data.
  - The LED outputs change the same edge.
  - Writes to read-only offsets are ignored.
- Read and write of the same LED register in one cycle: rd_data returns the old value.
- Reset mid-press: the FSM returns to IDLE and counters clear. A still-held button must re-debounce fully before a code appears.
- Glitch shorter than DEBOUNCE_CYCLES: no change to any debounced value or code.

Test Plan (bench uses DEBOUNCE_CYCLES=4, BASE_ADDR=16'hFFF0):
- Reset, then read FFF0..FFF7 -> all rd_data=0000; hit=1 one cycle after each address; led_addr=led_data=0; stop=0.
- Set sw_addr=1234, sw_reg=3 and hold 10 cycles, then read FFF0 and FFF2 -> 1234 and 0003. A 2-cycle glitch to FFFF beforehand leaves the value 0000 until stable.
- Press btn[3] for 12 cycles then release -> CTRL_SWITCHES=0004 from 2+4 cycles after the press, held while pressed, then 0000. STATUS bit0 follows HELD/RELEASE.
- Press btn[1] and btn[5] together -> code 0002. Release btn[1] while btn[5] is still held -> code stays 0002 until both are released, then RELEASE→IDLE; a fresh btn[5] press then gives 0006.
- Write FFF3=ABCD and FFF4=5678, with write to FFF0 and to 0010 (outside the window) -> led_addr=ABCD, led_data=5678, no change elsewhere. Reading FFF3 in the write cycle returns the old 0000, and the next read returns ABCD.
- Assert reset while btn[2] is held in HELD -> code=0 and led_* =0 immediately. The code returns to 0003 only after the re-debounce delay (2+4 cycles after reset deasserts).
